// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - per-register pending-write scoreboard gating decode-to-execute issue
// Tracks outstanding writes, stalls RAW/WAW/fence hazards, supports flush and writeback bypass.
module issue_scoreboard #(
  parameter int NREGS  = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              u_valid,
  output logic              u_rdy,
  input  logic [REG_W-1:0]  rs1,
  input  logic              rs1_en,
  input  logic [REG_W-1:0]  rs2,
  input  logic              rs2_en,
  input  logic [REG_W-1:0]  rd,
  input  logic              rd_en,
  input  logic              fence,
  output logic              d_valid,
  input  logic              d_rdy,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic              flush,
  output logic              sb_empty,
  output logic [31:0]       stall_cycles,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt     [NREGS];
  logic [CNT_W-1:0] w_cnt_nxt [NREGS];
  logic             r_sb_empty;
  logic [31:0]      r_stall;
  logic             r_err;

  logic [CNT_W-1:0] w_cnt_rs1;
  logic [CNT_W-1:0] w_cnt_rs2;
  logic [CNT_W-1:0] w_cnt_rd;
  logic [CNT_W-1:0] w_cnt_wb;
  logic             w_raw1;
  logic             w_raw2;
  logic             w_waw;
  logic             w_fnc;
  logic             w_hazard;
  logic             w_fire;
  logic             w_inc;
  logic             w_dec;
  logic             w_same;
  logic             w_underflow;
  logic             w_overflow;
  logic             w_all_zero;
  logic             w_stall_inc;

  assign w_cnt_rs1 = r_cnt[rs1];
  assign w_cnt_rs2 = r_cnt[rs2];
  assign w_cnt_rd  = r_cnt[rd];
  assign w_cnt_wb  = r_cnt[wb_rd];

  // A writeback retiring the last pending write of a source resolves its RAW now.
  always_comb begin
    w_raw1 = rs1_en && (rs1 != '0) && (w_cnt_rs1 != '0) &&
             !((BYPASS != 0) && wb_valid && (wb_rd == rs1) && (w_cnt_rs1 == CNT_ONE));
    w_raw2 = rs2_en && (rs2 != '0) && (w_cnt_rs2 != '0) &&
             !((BYPASS != 0) && wb_valid && (wb_rd == rs2) && (w_cnt_rs2 == CNT_ONE));
    w_waw  = rd_en && (rd != '0) && (w_cnt_rd == CNT_MAX);
    w_fnc  = fence && !r_sb_empty;
    w_hazard = w_raw1 || w_raw2 || w_waw || w_fnc;
  end

  assign d_valid = u_valid && !w_hazard && !flush && !rst;
  assign u_rdy   = d_rdy   && !w_hazard && !flush && !rst;
  assign w_fire  = u_valid && u_rdy;

  assign w_inc       = w_fire && rd_en && (rd != '0);
  assign w_dec       = wb_valid && (wb_rd != '0) && (w_cnt_wb != '0);
  assign w_same      = w_inc && w_dec && (rd == wb_rd);
  assign w_underflow = wb_valid && (wb_rd != '0) && (w_cnt_wb == '0);
  assign w_overflow  = w_inc && !w_same && (w_cnt_rd == CNT_MAX);
  assign w_stall_inc = u_valid && !u_rdy && !flush && !rst;

  // Next-state counters; x0 is pinned to zero and flush wins over everything.
  always_comb begin
    w_all_zero = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (flush || (i == 0)) begin
        w_cnt_nxt[i] = '0;
      end else if (!w_same) begin
        if (w_inc && (rd == REG_W'(i)) && (r_cnt[i] != CNT_MAX)) begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
        end
        if (w_dec && (wb_rd == REG_W'(i))) begin
          w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
        end
      end
      if (w_cnt_nxt[i] != '0) begin
        w_all_zero = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_cnt[i] <= '0;
      end
      r_sb_empty <= 1'b1;
      r_stall    <= '0;
      r_err      <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_sb_empty <= w_all_zero;
      if (w_stall_inc && (r_stall != 32'hFFFF_FFFF)) begin
        r_stall <= r_stall + 32'd1;
      end
      if (!flush && (w_underflow || w_overflow)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign sb_empty     = r_sb_empty;
  assign stall_cycles = r_stall;
  assign err          = r_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed vector bench for issue_scoreboard
// Runs a BYPASS=1 and a BYPASS=0 instance on shared stimulus.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst, u_valid, rs1_en, rs2_en, rd_en, fence, d_rdy, wb_valid, flush;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        u_rdy1, d_valid1, sb_empty1, err1;
  logic [31:0] stall1;
  logic        u_rdy0, d_valid0, sb_empty0, err0;
  logic [31:0] stall0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  issue_scoreboard #(.NREGS(32), .REG_W(5), .CNT_W(2), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .u_valid(u_valid), .u_rdy(u_rdy1),
    .rs1(rs1), .rs1_en(rs1_en), .rs2(rs2), .rs2_en(rs2_en),
    .rd(rd), .rd_en(rd_en), .fence(fence), .d_valid(d_valid1), .d_rdy(d_rdy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .sb_empty(sb_empty1), .stall_cycles(stall1), .err(err1)
  );

  issue_scoreboard #(.NREGS(32), .REG_W(5), .CNT_W(2), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .u_valid(u_valid), .u_rdy(u_rdy0),
    .rs1(rs1), .rs1_en(rs1_en), .rs2(rs2), .rs2_en(rs2_en),
    .rd(rd), .rd_en(rd_en), .fence(fence), .d_valid(d_valid0), .d_rdy(d_rdy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .sb_empty(sb_empty0), .stall_cycles(stall0), .err(err0)
  );

  typedef struct {
    logic        rst, uv;
    logic [4:0]  rs1;
    logic        r1e;
    logic [4:0]  rs2;
    logic        r2e;
    logic [4:0]  rd;
    logic        rde, fen, drdy, wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        e_urdy, e_dv, e_empty, e_err;
    logic [31:0] e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mv(
    logic r, logic uv, logic [4:0] a, logic ae, logic [4:0] b, logic be,
    logic [4:0] d, logic de, logic fe, logic dr, logic wv, logic [4:0] wr, logic fl,
    logic eu, logic ed, logic ee, logic er, logic [31:0] es);
    vec_t v;
    v.rst = r; v.uv = uv; v.rs1 = a; v.r1e = ae; v.rs2 = b; v.r2e = be;
    v.rd = d; v.rde = de; v.fen = fe; v.drdy = dr; v.wbv = wv; v.wbrd = wr; v.fl = fl;
    v.e_urdy = eu; v.e_dv = ed; v.e_empty = ee; v.e_err = er; v.e_stall = es;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; u_valid = v.uv; rs1 = v.rs1; rs1_en = v.r1e; rs2 = v.rs2; rs2_en = v.r2e;
    rd = v.rd; rd_en = v.rde; fence = v.fen; d_rdy = v.drdy;
    wb_valid = v.wbv; wb_rd = v.wbrd; flush = v.fl;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      n_miss++;
    end
  endtask

  initial begin
    //               rst uv rs1 e rs2 e rd e fen drdy wbv wbrd fl | urdy dv empty err stall
    vecs.push_back(mv(1, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0));
    vecs.push_back(mv(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mv(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 5, 0,   1, 1, 0, 0, 1));
    vecs.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 1));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0,   1, 1, 1, 0, 1));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 1));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 1));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 1));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 1, 7, 0,   0, 0, 0, 0, 2));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 1, 7, 0,   1, 1, 0, 0, 3));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 3));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 3));
    vecs.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0,   1, 0, 0, 0, 4));
    vecs.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0,   1, 0, 0, 0, 4));
    vecs.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0,   1, 0, 0, 0, 4));
    vecs.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 4));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0,   1, 1, 1, 0, 4));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 4));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 4));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 0,   0, 0, 0, 0, 5));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 0,   0, 0, 0, 0, 6));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,   1, 1, 1, 0, 7));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0,   1, 1, 1, 0, 7));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 7));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 7));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 7));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 7));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 7));
    vecs.push_back(mv(0, 1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 7));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 4, 1, 0, 1, 1, 9, 1,   0, 0, 0, 0, 8));
    vecs.push_back(mv(0, 1, 1, 1, 3, 1, 0, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 8));
    vecs.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0,   1, 0, 1, 0, 8));
    vecs.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 1, 1, 8));
    vecs.push_back(mv(0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0,   1, 1, 1, 1, 8));
    vecs.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 1, 1, 8));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 8));
    vecs.push_back(mv(0, 1, 0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 0,   1, 1, 1, 1, 9));
    vecs.push_back(mv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 9));
    vecs.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0));
    vecs.push_back(mv(0, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0));

    drive(mv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k]);
      #1;
      n_vec++;
      chk("u_rdy",        k, {31'd0, u_rdy1},    {31'd0, vecs[k].e_urdy});
      chk("d_valid",      k, {31'd0, d_valid1},  {31'd0, vecs[k].e_dv});
      chk("sb_empty",     k, {31'd0, sb_empty1}, {31'd0, vecs[k].e_empty});
      chk("err",          k, {31'd0, err1},      {31'd0, vecs[k].e_err});
      chk("stall_cycles", k, stall1,             vecs[k].e_stall);
    end

    // Bypass disabled: RAW against a retiring write only clears one cycle later.
    @(negedge clk);
    drive(mv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mv(0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    #1;
    n_vec++;
    chk("nobyp_issue_rd5", 100, {31'd0, u_rdy0}, 32'd1);
    chk("nobyp_empty0",    100, {31'd0, sb_empty0}, 32'd1);
    @(negedge clk);
    drive(mv(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 5, 0,  0, 0, 0, 0, 0));
    #1;
    n_vec++;
    chk("nobyp_raw_urdy",  101, {31'd0, u_rdy0},   32'd0);
    chk("nobyp_raw_dv",    101, {31'd0, d_valid0}, 32'd0);
    chk("byp_raw_urdy",    101, {31'd0, u_rdy1},   32'd1);
    chk("nobyp_empty1",    101, {31'd0, sb_empty0}, 32'd0);
    @(negedge clk);
    drive(mv(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    #1;
    n_vec++;
    chk("nobyp_late_urdy", 102, {31'd0, u_rdy0},   32'd1);
    chk("nobyp_late_dv",   102, {31'd0, d_valid0}, 32'd1);
    chk("nobyp_stall",     102, stall0,            32'd1);
    chk("nobyp_err",       102, {31'd0, err0},     32'd0);
    chk("nobyp_empty2",    102, {31'd0, sb_empty0}, 32'd1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue-control block between the decode stage and execute.
- Tracks outstanding register writes per architectural register in a counter scoreboard.
- Stalls decoded uops on RAW/WAW/fence hazards, with optional same-cycle writeback bypass.
- Passes hazard-free uops downstream over the valid/ready handshake, and supports pipeline flush.

Parameters:
- NREGS, 32, number of architectural registers; x0 never tracked.
- REG_W, 5, register index width, $clog2(NREGS).
- CNT_W, 2, per-register pending-write counter width; max outstanding writes per register = 2^CNT_W-1.
- BYPASS, 1, 1 = writeback retiring the last pending write clears a RAW hazard in the same cycle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- u_valid  in  1  decoded uop valid from decode stage
- u_rdy  out  1  block accepts uop this cycle
- rs1  in  REG_W  source 1 index
- rs1_en  in  1  uop reads rs1
- rs2  in  REG_W  source 2 index
- rs2_en  in  1  uop reads rs2
- rd  in  REG_W  destination index
- rd_en  in  1  uop writes rd
- fence  in  1  uop requires empty scoreboard before issue
- d_valid  out  1  uop valid to execute
- d_rdy  in  1  execute accepts uop
- wb_valid  in  1  a register write retires
- wb_rd  in  REG_W  retiring destination
- flush  in  1  kill all in-flight writes, clear scoreboard
- sb_empty  out  1  all counters zero (registered view)
- stall_cycles  out  32  saturating count of cycles with u_valid=1, u_rdy=0, no flush
- err  out  1  sticky: writeback to register with zero count, or counter overflow attempt

Behaviour:
- Reset (rst=1): all counters 0, err=0, stall_cycles=0, sb_empty=1. u_rdy=0 and d_valid=0 while rst is high.
- Issue is combinational (zero latency). No uop storage in this block.
  - hazard = raw1 | raw2 | waw | fnc
  - raw1 = rs1_en & rs1!=0 & cnt[rs1]!=0 & !(BYPASS & wb_valid & wb_rd==rs1 & cnt[rs1]==1); raw2 is the same for rs2.
  - waw = rd_en & rd!=0 & cnt[rd]==max (saturated, must wait).
  - fnc = fence & !sb_empty.
  - d_valid = u_valid & !hazard & !flush & !rst.
  - u_rdy = d_rdy & !hazard & !flush & !rst.
  - fire = u_valid & u_rdy.
- d_valid must not depend on d_rdy (no combinational loop). uop fields pass through unchanged; this block only gates the handshake.
- Counter update, each clock:
  - inc = fire & rd_en & rd!=0.
  - dec = wb_valid & wb_rd!=0 & cnt[wb_rd]!=0.
  - Same register inc and dec in the same cycle: count unchanged.
  - Different registers: both update.
- Boundary conditions:
  - Underflow: wb_valid to a register with count 0 (wb_rd!=0) leaves the counter at 0 and sets err.
  - Overflow: cannot occur through the handshake because waw blocks it. err is set defensively if an inc would wrap.
  - x0: never counted. A writeback to x0 is ignored with no err.
- Flush: when flush=1, no issue that cycle; the next cycle all counters are 0 and sb_empty=1. A wb_valid in the flush cycle is discarded with no err. Flush has priority over every other update.
- sb_empty: registered, equals (all next counters == 0), so it lags the counters by zero cycles relative to the registered state.
- stall_cycles: increments by 1 each cycle with u_valid & !u_rdy & !flush & !rst, saturates at 0xFFFFFFFF. Not cleared by flush.
- err: sticky until rst.
- Reset mid-operation: all state returns to reset values on the next clock, regardless of pending writebacks.

Test Plan:
- Reset, then u_valid=1, rd=5, rd_en=1, d_rdy=1 -> d_valid=u_rdy=1; next cycle cnt[5]=1, sb_empty=0.
- With cnt[5]=1: uop rs1=5, rs1_en=1 -> u_rdy=0, d_valid=0, stall_cycles increments. Same cycle wb_valid=1, wb_rd=5 with BYPASS=1 -> fires; with BYPASS=0 -> fires one cycle later.
- Issue 3 writes to rd=7 (CNT_W=2) -> 4th uop writing rd=7 stalls (waw). One wb_rd=7 -> 4th issues. Same-cycle issue plus wb to reg 7 -> count stays 3.
- fence=1 uop with cnt[3]=2 -> stalls until two wb_rd=3 retire; issues the cycle sb_empty=1.
- Counters at 3,1,2 on regs 1,2,3; assert flush with u_valid=1 and wb_valid=1 -> no fire, next cycle all counts 0, sb_empty=1, err=0.
- wb_valid=1, wb_rd=9 with cnt[9]=0 -> err=1 and stays 1. wb_rd=0 -> no err. rst -> err=0, stall_cycles=0.
